fetch_unit: RTL and testbench

- Instruction-fetch front end that initiates reads to the 4096 x 16 instruction memory.
- Owns the program counter and drives the memory address port (PCAdd_pc).
- Captures the combinationally returned word (M_instruction) into an IF/ID pipeline register.
- Handles start-up, pipeline stall, branch redirect/flush, and halt on a HALT opcode.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_pc_next_sel.sv | 23 ++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, opcodes and the fetch state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_SUBI = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port plus the IF/ID pipeline register outputs of the fetch stage.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  PCAdd_pc;
  logic [INSTR_W-1:0] M_instruction;
  logic [INSTR_W-1:0] IF_instruction;
  logic [ADDR_W-1:0]  IF_pc;
  logic [ADDR_W-1:0]  IF_pc_plus1;
  logic               IF_valid;

  modport master (
    output PCAdd_pc,
    input  M_instruction,
    output IF_instruction,
    output IF_pc,
    output IF_pc_plus1,
    output IF_valid
  );

  modport slave (
    input  PCAdd_pc,
    output M_instruction,
    input  IF_instruction,
    input  IF_pc,
    input  IF_pc_plus1,
    input  IF_valid
  );
endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection: redirect beats stall/halt, otherwise sequential advance with wrap.
module pc_next_sel #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              run,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_hit,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (br_taken) begin
      pc_next = br_target;
    end else if (run && !stall && !halt_hit) begin
      pc_next = pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and registers the fetched word into IF/ID.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0,
  parameter logic [3:0]         HALT_OP  = OP_HALT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  fetch_unit_if.master       bus,
  output logic               halted
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              redirect, fetch_en, halt_hit;

  // Branches are honoured in RUN and HALT only; stall never blocks a redirect.
  assign redirect = br_taken && (state != IDLE);
  assign fetch_en = (state == RUN) && !stall && !redirect;
  assign halt_hit = fetch_en && (opcode_of(bus.M_instruction) == HALT_OP);

  assign bus.PCAdd_pc = pc;
  assign halted       = (state == HALT);

  pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
    .pc        (pc),
    .run       (state == RUN),
    .stall     (stall),
    .br_taken  (redirect),
    .br_target (br_target),
    .halt_hit  (halt_hit),
    .pc_next   (pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (redirect) state_next = RUN;
               else if (halt_hit) state_next = HALT;
      HALT:    if (redirect) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.IF_instruction <= NOP_WORD;
      bus.IF_pc          <= '0;
      bus.IF_pc_plus1    <= '0;
      bus.IF_valid       <= 1'b0;
    end else if (redirect) begin
      bus.IF_instruction <= NOP_WORD;
      bus.IF_valid       <= 1'b0;
    end else if (fetch_en) begin
      bus.IF_instruction <= bus.M_instruction;
      bus.IF_pc          <= pc;
      bus.IF_pc_plus1    <= pc + ADDR_W'(1);
      bus.IF_valid       <= 1'b1;
    end else if (state != RUN) begin
      bus.IF_valid       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a cycle-level behavioural model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, stall, br_taken, halted;
  logic [11:0] br_target;
  logic [15:0] mem [4096];

  always #5 clk = ~clk;

  fetch_unit_if bus ();
  assign bus.M_instruction = mem[bus.PCAdd_pc];

  fetch_unit #(.RESET_PC(12'h000), .NOP_WORD(16'h0000), .HALT_OP(4'hF)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .bus       (bus),
    .halted    (halted)
  );

  // Reference model: plain integers and flags describing what the fetch stage should show.
  int          m_pc, m_ifpc, m_plus1;
  logic [15:0] m_instr;
  bit          m_running, m_halted, m_valid;
  int          n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [15:0] w;
    if (reset) begin
      m_pc = 0; m_running = 0; m_halted = 0;
      m_instr = 16'h0000; m_ifpc = 0; m_plus1 = 0; m_valid = 0;
    end else if (!m_running && !m_halted) begin
      m_valid = 0;
      if (start) m_running = 1;
    end else if (br_taken) begin
      m_pc = int'(br_target); m_valid = 0; m_instr = 16'h0000;
      m_running = 1; m_halted = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (!stall) begin
      w = mem[m_pc];
      m_instr = w; m_ifpc = m_pc; m_plus1 = (m_pc + 1) % 4096; m_valid = 1;
      if (w[15:12] == 4'hF) begin
        m_halted = 1; m_running = 0;
      end else begin
        m_pc = (m_pc + 1) % 4096;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pcadd",  32'(bus.PCAdd_pc),       32'(m_pc));
    chk("instr",  32'(bus.IF_instruction), 32'(m_instr));
    chk("if_pc",  32'(bus.IF_pc),          32'(m_ifpc));
    chk("plus1",  32'(bus.IF_pc_plus1),    32'(m_plus1));
    chk("valid",  32'(bus.IF_valid),       32'(m_valid));
    chk("halted", 32'(halted),             32'(m_halted));
  endtask

  task automatic run_to_pc(input int target);
    for (int i = 0; i < 64 && m_pc != target; i++) tick();
    chk("reach_pc", 32'(bus.PCAdd_pc), 32'(target));
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1; start = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    for (int i = 0; i < 4096; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h6;
      mem[i] = w;
    end
    mem[0] = 16'h6181; mem[1] = 16'h6242; mem[2] = 16'h6313; mem[9] = 16'hF000;

    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_pc", 32'(bus.PCAdd_pc), 32'd0);
    chk("idle_valid", 32'(bus.IF_valid), 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    chk("run0_pc", 32'(bus.PCAdd_pc), 32'd0);
    chk("run0_valid", 32'(bus.IF_valid), 32'd0);
    tick();
    chk("f0_instr", 32'(bus.IF_instruction), 32'h6181);
    chk("f0_pc", 32'(bus.PCAdd_pc), 32'd1);
    tick();
    chk("f1_instr", 32'(bus.IF_instruction), 32'h6242);
    tick();
    chk("f2_instr", 32'(bus.IF_instruction), 32'h6313);
    chk("f2_ifpc", 32'(bus.IF_pc), 32'd2);

    run_to_pc(5);
    stall = 1'b1;
    repeat (3) tick();
    chk("stall_pc", 32'(bus.PCAdd_pc), 32'd5);
    chk("stall_ifpc", 32'(bus.IF_pc), 32'd4);
    stall = 1'b0;
    tick();
    chk("resume_ifpc", 32'(bus.IF_pc), 32'd5);

    run_to_pc(6);
    stall = 1'b1; br_taken = 1'b1; br_target = 12'd2;
    tick();
    stall = 1'b0; br_taken = 1'b0;
    chk("br_pc", 32'(bus.PCAdd_pc), 32'd2);
    chk("br_valid", 32'(bus.IF_valid), 32'd0);
    chk("br_instr", 32'(bus.IF_instruction), 32'h0000);
    tick();
    chk("br_fetch", 32'(bus.IF_instruction), 32'h6313);

    run_to_pc(9);
    tick();
    chk("halt_word", 32'(bus.IF_instruction), 32'hF000);
    chk("halt_word_valid", 32'(bus.IF_valid), 32'd1);
    for (int i = 0; i < 12; i++) begin
      stall = 1'($urandom); start = 1'($urandom);
      tick();
    end
    stall = 1'b0; start = 1'b0;
    chk("halt_pc", 32'(bus.PCAdd_pc), 32'd9);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_valid", 32'(bus.IF_valid), 32'd0);

    br_taken = 1'b1; br_target = 12'd0;
    tick();
    br_taken = 1'b0;
    chk("restart_halted", 32'(halted), 32'd0);
    tick();
    chk("restart_fetch", 32'(bus.IF_instruction), 32'h6181);

    br_taken = 1'b1; br_target = 12'd4095;
    tick();
    br_taken = 1'b0;
    tick();
    chk("wrap_ifpc", 32'(bus.IF_pc), 32'd4095);
    chk("wrap_plus1", 32'(bus.IF_pc_plus1), 32'd0);
    chk("wrap_pc", 32'(bus.PCAdd_pc), 32'd0);

    reset = 1'b1; br_taken = 1'b1; br_target = 12'd77; stall = 1'b1;
    tick();
    reset = 1'b0; br_taken = 1'b0; stall = 1'b0;
    chk("rst_pc", 32'(bus.PCAdd_pc), 32'd0);
    chk("rst_valid", 32'(bus.IF_valid), 32'd0);
    br_taken = 1'b1; br_target = 12'd40;
    repeat (3) tick();
    br_taken = 1'b0;
    chk("rst_idle_pc", 32'(bus.PCAdd_pc), 32'd0);

    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    start = 1'b1; tick();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(63) == 0);
      start     = 1'($urandom);
      stall     = ($urandom_range(9) < 3);
      br_taken  = ($urandom_range(19) == 0);
      br_target = 12'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
